// File: rtl/lane_sep_merge_pipe_if.sv
// Stream interface for lane_sep_merge_pipe: input word, mode, slip,
// output word, rotation status and (with LANE_SEP_MERGE_PARITY_EN) lane parity.
interface lane_sep_merge_pipe_if #(
  parameter int WIDTH = 20,
  parameter int LANES = 2
) ();
  localparam int RW = $clog2(LANES);

  logic             mode;
  logic             slip;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic [RW-1:0]    rot;
`ifdef LANE_SEP_MERGE_PARITY_EN
  logic [LANES-1:0] dout_par;

  modport slave (
    input  mode, slip, din, din_valid, dout_ready,
    output din_ready, dout, dout_valid, rot, dout_par
  );
  modport master (
    output mode, slip, din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid, rot, dout_par
  );
`else
  modport slave (
    input  mode, slip, din, din_valid, dout_ready,
    output din_ready, dout, dout_valid, rot
  );
  modport master (
    output mode, slip, din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid, rot
  );
`endif
endinterface

// File: rtl/lane_sep_merge_pipe.sv
// lane_sep_merge_pipe: registered bit-interleave lane separator / merger with
// run-time lane rotation and a two-entry (output + skid) valid/ready pipeline.
// Optional macro LANE_SEP_MERGE_PARITY_EN adds per-lane even parity (dout_par).
module lane_sep_merge_pipe #(
  parameter int WIDTH = 20,
  parameter int LANES = 2
) (
  input logic              clk,
  input logic              arst,
  lane_sep_merge_pipe_if.slave bus
);
  localparam int S  = WIDTH / LANES;
  localparam int RW = $clog2(LANES);

  // Refuse to elaborate with a lane count / width combination that cannot stripe.
  generate
    if (LANES < 2 || (LANES & (LANES - 1)) != 0 || (WIDTH % LANES) != 0) begin : g_param_check
      $error("lane_sep_merge_pipe: illegal WIDTH/LANES combination");
    end
  endgenerate

  logic [RW-1:0]    rot_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] skid_data_reg;
  logic             skid_valid_reg;

  logic [WIDTH-1:0] sep_base;   // separated word at rotation 0
  logic [WIDTH-1:0] sep_rot;    // separated word, lanes rotated up by rot
  logic [WIDTH-1:0] mrg_rot;    // input lanes rotated down by rot
  logic [WIDTH-1:0] mrg_out;    // merged word
  logic [WIDTH-1:0] xf_word;
  int unsigned      rot_amt;

  logic accept;
  logic out_free;

  // Static interleave: input bit k*LANES+l lands in lane l, position k; merge is the inverse.
  genvar gi, gj;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      for (gj = 0; gj < S; gj++) begin : g_bit
        assign sep_base[gi*S + gj] = bus.din[gj*LANES + gi];
        assign mrg_out[gj*LANES + gi] = mrg_rot[gi*S + gj];
      end
    end
  endgenerate

  // Lane rotation as a word rotate by rot*S bits, then pick the transform for this mode.
  always_comb begin
    rot_amt = 32'(rot_reg) * 32'(S);
    sep_rot = (sep_base << rot_amt) | (sep_base >> (32'(WIDTH) - rot_amt));
    mrg_rot = (bus.din >> rot_amt) | (bus.din << (32'(WIDTH) - rot_amt));
    xf_word = bus.mode ? mrg_out : sep_rot;
  end

  // din_ready is purely the registered "skid empty" flag, so no path from dout_ready.
  assign accept   = bus.din_valid && !skid_valid_reg;
  assign out_free = !out_valid_reg || bus.dout_ready;

`ifdef LANE_SEP_MERGE_PARITY_EN
  logic [LANES-1:0] xf_par;
  logic [LANES-1:0] out_par_reg;
  logic [LANES-1:0] skid_par_reg;

  generate
    for (gi = 0; gi < LANES; gi++) begin : g_par
      assign xf_par[gi] = ^xf_word[gi*S +: S];
    end
  endgenerate

  // Parity travels with its word through the output and skid registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      out_par_reg  <= '0;
      skid_par_reg <= '0;
    end else if (out_free) begin
      if (skid_valid_reg)
        out_par_reg <= skid_par_reg;
      else if (accept)
        out_par_reg <= xf_par;
    end else if (accept) begin
      skid_par_reg <= xf_par;
    end
  end

  assign bus.dout_par = out_par_reg;
`endif

  // Rotation counter advances on every slip pulse, independent of the handshake.
  always_ff @(posedge clk or posedge arst) begin
    if (arst)
      rot_reg <= '0;
    else if (bus.slip)
      rot_reg <= rot_reg + RW'(1);
  end

  // Output register refills from skid first (ordering), else from a fresh accept; skid catches stalls.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      skid_data_reg  <= '0;
      skid_valid_reg <= 1'b0;
    end else if (out_free) begin
      if (skid_valid_reg) begin
        out_data_reg   <= skid_data_reg;
        out_valid_reg  <= 1'b1;
        skid_valid_reg <= 1'b0;
      end else if (accept) begin
        out_data_reg  <= xf_word;
        out_valid_reg <= 1'b1;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      skid_data_reg  <= xf_word;
      skid_valid_reg <= 1'b1;
    end
  end

  assign bus.din_ready  = !skid_valid_reg;
  assign bus.dout       = out_data_reg;
  assign bus.dout_valid = out_valid_reg;
  assign bus.rot        = rot_reg;
endmodule

// File: doc/lane_sep_merge_pipe.md
Name: lane_sep_merge_pipe

Overview:
- Parametrised, registered successor to the combinational odd/even bit separator.
- Splits a WIDTH-bit word into LANES bit-interleaved lanes (separate mode), or reassembles them (merge mode).
- Supports a run-time lane rotation for alignment slip.
- Sits between the SL3 PCS/FEC data path and the lane-striped user logic; valid/ready handshake with full backpressure.

Parameters:
- WIDTH, 20, data word width in bits; must be a multiple of LANES.
- LANES, 2, lane count; power of 2, 2..16. S = WIDTH/LANES bits per lane. RW = log2(LANES).

Ports:
- clk  in  1  sole clock
- arst  in  1  asynchronous, active-high reset
- mode  in  1  0 = separate, 1 = merge; sampled with each accepted word
- slip  in  1  single-cycle pulse; advances lane rotation by one
- din  in  WIDTH  input word
- din_valid  in  1  input word valid
- din_ready  out  1  block can accept a word this cycle
- dout  out  WIDTH  transformed word
- dout_valid  out  1  output word valid
- dout_ready  in  1  downstream accepts dout
- rot  out  RW  current lane rotation, 0..LANES-1

Behaviour:
- Clocking and reset: one clock, clk. Reset arst is asynchronous and active-high.
- Reset values: dout = 0, dout_valid = 0, din_ready = 1, rot = 0, skid buffer empty, dout_par = 0.
- Separate mapping: for bit i, l = i mod LANES, k = i / LANES: dout[((l+rot) mod LANES)*S + k] = din[i].
  - With LANES = 2 and rot = 0 this is exactly the legacy odd/even split: even bits go low, odd bits go high.
- Merge mapping (exact inverse for the same rot): for bit j, b = j / S, k = j mod S, l = (b - rot) mod LANES: dout[k*LANES + l] = din[j].
  - merge(separate(x, r), r) == x for all x, r.
- Transform input sampling: the transform is applied at accept time using that cycle's mode and rot. The stored word is never re-transformed.
- Handshake:
  - A word is accepted when din_valid && din_ready.
  - dout is transferred when dout_valid && dout_ready.
- Buffering: two-entry pipeline, consisting of the output register plus a skid register.
  - din_ready is registered and equals "skid register empty"; it never depends combinationally on dout_ready.
- Latency: one cycle. A word accepted at edge N appears on dout with dout_valid = 1 after edge N, provided the output register is empty or draining at edge N.
- Output stall: while dout_valid && !dout_ready, dout and dout_valid hold stable. A word accepted during the stall goes to the skid register, and din_ready drops at the next edge.
- Skid drain: when the output drains and the skid register is full, the skid word moves to the output register on that edge, and din_ready returns to 1 on the same edge.
- Full throughput: with dout_ready held at 1, one word is accepted and one delivered every cycle; the skid register stays unused.
- Ordering: words are delivered in order. No drop, no duplication.
- Rotation counter:
  - rot increments mod LANES at each edge where slip = 1; LANES-1 wraps to 0.
  - slip is independent of the handshake.
  - If slip and an accept occur in the same cycle, the accepted word uses the pre-increment rot.
- Mode: may change every word. The mode of a stalled word is the mode it was accepted with.
- Reset mid-operation: both buffer entries are discarded and rot returns to 0; outputs go to their reset values immediately.
- Elaboration checks: an illegal parameter set (WIDTH mod LANES != 0, or LANES not a power of 2, or LANES < 2) must stop elaboration.

Optional Feature:
- Macro: LANE_SEP_MERGE_PARITY_EN.
- Defined: adds output port dout_par (LANES bits).
  - dout_par[l] = XOR of dout[l*S +: S], i.e. even parity of output lane l.
  - Computed at accept time and stored alongside the word; it follows the same stall and skid rules as dout.
  - Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, LANES=2, mode=0, rot=0, din=0xA6, dout_ready=1 -> dout=0xD2 with dout_valid one cycle after accept. With parity enabled, dout_par=2'b11.
- WIDTH=8, LANES=4, mode=0, din=0x1B -> dout=0x47. Then mode=1, din=0x47 -> dout=0x1B. Back-to-back, one word per cycle.
- LANES=2: pulse slip once -> rot=1. Then din=0xA6, mode=0 -> dout=0x2D. Pulse slip again -> rot wraps to 0. Slip in the same cycle as an accept -> that word uses the old rot.
- Backpressure: hold dout_ready=0 and drive 3 words 0x01, 0x02, 0x03.
  - 0x01 holds on dout.
  - 0x02 is accepted into skid; din_ready goes 0 and 0x03 is not accepted.
  - Release dout_ready -> 0x01, 0x02, 0x03 are delivered in order with no loss.
- Assert arst while both entries are full and rot=1 -> dout_valid=0, dout=0, din_ready=1, rot=0 immediately. After release, the first new word passes with rot=0.
- Randomised: mode, rot and stalls with WIDTH=20, LANES=4 -> a scoreboard model matches every delivered word, and separate followed by merge returns the original word.
